priority_resolver_n: RTL and testbench

Parametrised, clocked successor to the interrupt priority resolver in the 8259A-style PIC. It handles N_IRQ request lines and maintains the IRR, ISR and IMR registers. It resolves fixed or rotating priority with fully nested masking and runs the two-pulse INTA handshake that returns the interrupt vector to the controller. It supports edge or level triggering, specific and non-specific EOI, rotate-on-EOI, set-priority, and automatic EOI with optional automatic rotation.

---
 rtl/priority_resolver_n.sv | 175 +++++++++++++++++
 tb/tb_priority_resolver_n.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/priority_resolver_n.sv
// Parametrised 8259A-style interrupt priority resolver: IRR/ISR/IMR, fixed or
// rotating priority with full nesting, two-pulse INTA handshake, EOI/AEOI.
module priority_resolver_n #(
  parameter int N_IRQ = 8,
  parameter int VEC_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_IRQ-1:0] ir,
  input  logic             ltim,
  input  logic             aeoi,
  input  logic             imr_wr,
  input  logic [N_IRQ-1:0] imr_din,
  input  logic             cmd_valid,
  input  logic [2:0]       cmd_op,
  input  logic [VEC_W-1:0] cmd_lvl,
  input  logic             inta,
  output logic             int_o,
  output logic [VEC_W-1:0] vec,
  output logic             vec_valid,
  output logic             spurious,
  output logic [N_IRQ-1:0] irr,
  output logic [N_IRQ-1:0] isr,
  output logic [N_IRQ-1:0] imr
);

  typedef enum logic {IDLE = 1'b0, ACK1 = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [N_IRQ-1:0] irr_q, irr_d, isr_q, isr_d, imr_q, imr_d, ir_q;
  logic [N_IRQ-1:0] pend, isr_clr, isr_set;
  logic [VEC_W-1:0] lowest_q, lowest_d, vec_r_q, vec_r_d, vec_q, vec_d;
  logic             spur_r_q, spur_r_d, auto_rot_q, auto_rot_d;
  logic             vec_valid_q, vec_valid_d, spurious_q, spurious_d;
  logic [VEC_W-1:0] idx, cand, top_isr, cand_rank, top_rank;
  logic             cand_found, top_found;
  logic             ack1, ack2, aeoi_clr, cmd_rot;
  logic [VEC_W-1:0] cmd_rot_lvl;

  // Walk from lowest priority up so the last hit is the highest-priority bit;
  // the loop index doubles as the rank (0 = highest).
  always_comb begin
    pend       = irr_q & ~imr_q;
    idx        = '0;
    cand       = '0;
    cand_rank  = '0;
    cand_found = 1'b0;
    top_isr    = '0;
    top_rank   = '0;
    top_found  = 1'b0;
    for (int k = N_IRQ - 1; k >= 0; k--) begin
      idx = lowest_q + VEC_W'(k + 1);
      if (pend[idx]) begin
        cand       = idx;
        cand_rank  = VEC_W'(k);
        cand_found = 1'b1;
      end
      if (isr_q[idx]) begin
        top_isr   = idx;
        top_rank  = VEC_W'(k);
        top_found = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (inta) state_d = ACK1;
      ACK1:    if (inta) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ack1        = (state_q == IDLE) && inta;
    ack2        = (state_q == ACK1) && inta;
    int_o       = (state_q == IDLE) && cand_found && (!top_found || (cand_rank < top_rank));
    vec_valid_d = ack2;
    spurious_d  = ack2 && spur_r_q;
    vec_d       = ack2 ? vec_r_q : vec_q;
  end

  always_comb begin
    aeoi_clr = ack2 && aeoi && !spur_r_q;
    if (ltim) begin
      irr_d = ir;
    end else begin
      irr_d = ir & (irr_q | ~ir_q);
      if (ack1 && cand_found) irr_d[cand] = 1'b0;
    end

    isr_clr     = '0;
    isr_set     = '0;
    cmd_rot     = 1'b0;
    cmd_rot_lvl = cmd_lvl;
    auto_rot_d  = auto_rot_q;
    if (cmd_valid) begin
      case (cmd_op)
        3'b001: if (top_found) isr_clr[top_isr] = 1'b1;
        3'b011: isr_clr[cmd_lvl] = 1'b1;
        3'b101: if (top_found) begin
          isr_clr[top_isr] = 1'b1;
          cmd_rot          = 1'b1;
          cmd_rot_lvl      = top_isr;
        end
        3'b111: begin
          isr_clr[cmd_lvl] = 1'b1;
          cmd_rot          = 1'b1;
        end
        3'b110: cmd_rot = 1'b1;
        3'b100: auto_rot_d = 1'b1;
        3'b000: auto_rot_d = 1'b0;
        default: ;
      endcase
    end
    if (aeoi_clr) isr_clr[vec_r_q] = 1'b1;
    // Setting after clearing lets a same-cycle acknowledge win over an EOI.
    if (ack1 && cand_found) isr_set[cand] = 1'b1;
    isr_d = (isr_q & ~isr_clr) | isr_set;

    lowest_d = lowest_q;
    if (aeoi_clr && auto_rot_q) lowest_d = vec_r_q;
    if (cmd_rot) lowest_d = cmd_rot_lvl;

    imr_d    = imr_wr ? imr_din : imr_q;
    vec_r_d  = vec_r_q;
    spur_r_d = spur_r_q;
    if (ack1) begin
      vec_r_d  = cand_found ? cand : VEC_W'(N_IRQ - 1);
      spur_r_d = !cand_found;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      irr_q       <= '0;
      isr_q       <= '0;
      imr_q       <= '0;
      ir_q        <= '0;
      lowest_q    <= VEC_W'(N_IRQ - 1);
      auto_rot_q  <= 1'b0;
      vec_r_q     <= '0;
      spur_r_q    <= 1'b0;
      vec_q       <= '0;
      vec_valid_q <= 1'b0;
      spurious_q  <= 1'b0;
    end else begin
      irr_q       <= irr_d;
      isr_q       <= isr_d;
      imr_q       <= imr_d;
      ir_q        <= ir;
      lowest_q    <= lowest_d;
      auto_rot_q  <= auto_rot_d;
      vec_r_q     <= vec_r_d;
      spur_r_q    <= spur_r_d;
      vec_q       <= vec_d;
      vec_valid_q <= vec_valid_d;
      spurious_q  <= spurious_d;
    end
  end

  assign vec       = vec_q;
  assign vec_valid = vec_valid_q;
  assign spurious  = spurious_q;
  assign irr       = irr_q;
  assign isr       = isr_q;
  assign imr       = imr_q;

endmodule

// File: tb/tb_priority_resolver_n.sv
// Bench for priority_resolver_n: directed vector table, a mid-handshake reset
// sequence, then random traffic against a rank-based reference model.
module tb_priority_resolver_n;
  localparam int N = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] ir, imr_din;
  logic       ltim, aeoi, imr_wr, cmd_valid, inta;
  logic [2:0] cmd_op, cmd_lvl;
  logic       int_o, vec_valid, spurious;
  logic [2:0] vec;
  logic [7:0] irr, isr, imr;

  int n_compared   = 0;
  int n_mismatched = 0;

  typedef struct {
    logic [7:0] ir;
    bit         ltim;
    bit         aeoi;
    int         imr;
    int         cmd;
    bit         inta;
    bit         e_int;
    logic [7:0] e_isr;
    logic [7:0] e_irr;
    bit         e_vv;
    int         e_vec;
    bit         e_spur;
  } row_t;
  row_t rows[$];

  logic [7:0] m_irr, m_isr, m_imr, m_irq;
  int         m_lowest, m_vecr, m_vec;
  bit         m_auto, m_ack, m_spurr, m_vv, m_spur;

  always #5 clk = ~clk;

  priority_resolver_n #(.N_IRQ(8), .VEC_W(3)) dut (
    .clk(clk), .rst(rst), .ir(ir), .ltim(ltim), .aeoi(aeoi),
    .imr_wr(imr_wr), .imr_din(imr_din), .cmd_valid(cmd_valid),
    .cmd_op(cmd_op), .cmd_lvl(cmd_lvl), .inta(inta), .int_o(int_o),
    .vec(vec), .vec_valid(vec_valid), .spurious(spurious),
    .irr(irr), .isr(isr), .imr(imr)
  );

  // Rank 0 is the highest priority: the level just after 'lowest'.
  function automatic int rank_of(input int b, input int low);
    return (b - low - 1 + 2 * N) % N;
  endfunction

  function automatic int pick_top(input logic [7:0] bits, input int low);
    int best = -1;
    for (int i = 0; i < N; i++)
      if (bits[i] && (best < 0 || rank_of(i, low) < rank_of(best, low))) best = i;
    return best;
  endfunction

  function automatic bit model_int();
    int c = pick_top(m_irr & ~m_imr, m_lowest);
    int t = pick_top(m_isr, m_lowest);
    return !m_ack && c >= 0 && (t < 0 || rank_of(c, m_lowest) < rank_of(t, m_lowest));
  endfunction

  task automatic model_reset();
    m_irr = 0; m_isr = 0; m_imr = 0; m_irq = 0;
    m_lowest = N - 1; m_vecr = 0; m_vec = 0;
    m_auto = 0; m_ack = 0; m_spurr = 0; m_vv = 0; m_spur = 0;
  endtask

  task automatic model_step(input logic [7:0] s_ir, input bit s_ltim, input bit s_aeoi,
                            input int s_imr, input int s_cmd, input bit s_inta);
    logic [7:0] n_irr, n_isr;
    int c, t, cmd_rot, n_low, op, lvl;
    bit n_auto, n_ack;
    c = pick_top(m_irr & ~m_imr, m_lowest);
    t = pick_top(m_isr, m_lowest);
    for (int i = 0; i < N; i++)
      n_irr[i] = s_ltim ? s_ir[i] : (s_ir[i] && (m_irr[i] || !m_irq[i]));
    n_isr = m_isr; n_low = m_lowest; n_auto = m_auto; n_ack = m_ack; cmd_rot = -1;
    if (s_cmd >= 0) begin
      op = s_cmd / 8; lvl = s_cmd % 8;
      case (op)
        1: if (t >= 0) n_isr[t] = 0;
        3: n_isr[lvl] = 0;
        5: if (t >= 0) begin n_isr[t] = 0; cmd_rot = t; end
        7: begin n_isr[lvl] = 0; cmd_rot = lvl; end
        6: cmd_rot = lvl;
        4: n_auto = 1;
        0: n_auto = 0;
        default: ;
      endcase
    end
    m_vv = 0; m_spur = 0;
    if (s_inta && m_ack) begin
      m_vv = 1; m_vec = m_vecr; m_spur = m_spurr; n_ack = 0;
      if (s_aeoi && !m_spurr) begin
        n_isr[m_vecr] = 0;
        if (m_auto) n_low = m_vecr;
      end
    end else if (s_inta) begin
      n_ack = 1;
      if (c >= 0) begin
        n_isr[c] = 1;
        if (!s_ltim) n_irr[c] = 0;
        m_vecr = c; m_spurr = 0;
      end else begin
        m_vecr = N - 1; m_spurr = 1;
      end
    end
    if (cmd_rot >= 0) n_low = cmd_rot;
    if (s_imr >= 0) m_imr = s_imr[7:0];
    m_irr = n_irr; m_isr = n_isr; m_irq = s_ir;
    m_lowest = n_low; m_auto = n_auto; m_ack = n_ack;
  endtask

  task automatic compare(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_compared++;
    if (act !== exp) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] s_ir, input bit s_ltim, input bit s_aeoi,
                               input int s_imr, input int s_cmd, input bit s_inta);
    ir        = s_ir;
    ltim      = s_ltim;
    aeoi      = s_aeoi;
    imr_wr    = (s_imr >= 0);
    imr_din   = (s_imr >= 0) ? s_imr[7:0] : 8'h00;
    cmd_valid = (s_cmd >= 0);
    cmd_op    = (s_cmd >= 0) ? s_cmd[5:3] : 3'd0;
    cmd_lvl   = (s_cmd >= 0) ? s_cmd[2:0] : 3'd0;
    inta      = s_inta;
    model_step(s_ir, s_ltim, s_aeoi, s_imr, s_cmd, s_inta);
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag);
    compare({tag, " int_o"},     int_o,     model_int());
    compare({tag, " vec_valid"}, vec_valid, m_vv);
    compare({tag, " spurious"},  spurious,  m_spur);
    compare({tag, " vec"},       vec,       m_vec);
    compare({tag, " irr"},       irr,       m_irr);
    compare({tag, " isr"},       isr,       m_isr);
    compare({tag, " imr"},       imr,       m_imr);
  endtask

  task automatic add_row(input logic [7:0] r_ir, input bit r_ltim, input bit r_aeoi,
                         input int r_imr, input int r_cmd, input bit r_inta,
                         input bit e_int, input logic [7:0] e_isr, input logic [7:0] e_irr,
                         input bit e_vv, input int e_vec, input bit e_spur);
    row_t r;
    r.ir = r_ir; r.ltim = r_ltim; r.aeoi = r_aeoi; r.imr = r_imr; r.cmd = r_cmd;
    r.inta = r_inta; r.e_int = e_int; r.e_isr = e_isr; r.e_irr = e_irr;
    r.e_vv = e_vv; r.e_vec = e_vec; r.e_spur = e_spur;
    rows.push_back(r);
  endtask

  logic [7:0] r_ir;
  int         r_imr, r_cmd;
  bit         r_inta;

  initial begin
    rst = 1'b1; ir = 0; ltim = 0; aeoi = 0; imr_wr = 0; imr_din = 0;
    cmd_valid = 0; cmd_op = 0; cmd_lvl = 0; inta = 0;
    model_reset();

    // cmd encoding: -1 none, else op*8 + lvl; imr: -1 none, else new mask
    // fixed priority, edge mode, NS-EOI
    add_row(8'h28,0,0,-1,-1,0, 1,8'h00,8'h28,0,0,0);
    add_row(8'h28,0,0,-1,-1,1, 0,8'h08,8'h20,0,0,0);
    add_row(8'h28,0,0,-1,-1,1, 0,8'h08,8'h20,1,3,0);
    add_row(8'h28,0,0,-1, 8,0, 1,8'h00,8'h20,0,3,0);
    add_row(8'h28,0,0,-1,-1,1, 0,8'h20,8'h00,0,3,0);
    add_row(8'h28,0,0,-1,-1,1, 0,8'h20,8'h00,1,5,0);
    add_row(8'h00,0,0,-1, 8,0, 0,8'h00,8'h00,0,5,0);
    // nesting under IR4
    add_row(8'h10,0,0,-1,-1,0, 1,8'h00,8'h10,0,5,0);
    add_row(8'h10,0,0,-1,-1,1, 0,8'h10,8'h00,0,5,0);
    add_row(8'h10,0,0,-1,-1,1, 0,8'h10,8'h00,1,4,0);
    add_row(8'h30,0,0,-1,-1,0, 0,8'h10,8'h20,0,4,0);
    add_row(8'h34,0,0,-1,-1,0, 1,8'h10,8'h24,0,4,0);
    add_row(8'h34,0,0,-1,-1,1, 0,8'h14,8'h20,0,4,0);
    add_row(8'h34,0,0,-1,-1,1, 0,8'h14,8'h20,1,2,0);
    add_row(8'h34,0,0,-1, 8,0, 0,8'h10,8'h20,0,2,0);
    add_row(8'h34,0,0,-1, 8,0, 1,8'h00,8'h20,0,2,0);
    add_row(8'h00,0,0,-1,-1,0, 0,8'h00,8'h00,0,2,0);
    // masked request, spurious handshake
    add_row(8'h01,0,0,255,-1,0, 0,8'h00,8'h01,0,2,0);
    add_row(8'h01,0,0,-1,-1,1,  0,8'h00,8'h01,0,2,0);
    add_row(8'h01,0,0,-1,-1,1,  0,8'h00,8'h01,1,7,1);
    add_row(8'h00,0,0, 0,-1,0,  0,8'h00,8'h00,0,7,0);
    // set priority lvl 4, rotate S-EOI lvl 6
    add_row(8'h00,0,0,-1,52,0, 0,8'h00,8'h00,0,7,0);
    add_row(8'h41,0,0,-1,-1,0, 1,8'h00,8'h41,0,7,0);
    add_row(8'h41,0,0,-1,-1,1, 0,8'h40,8'h01,0,7,0);
    add_row(8'h41,0,0,-1,-1,1, 0,8'h40,8'h01,1,6,0);
    add_row(8'h41,0,0,-1,62,0, 1,8'h00,8'h01,0,6,0);
    add_row(8'h41,0,0,-1,-1,1, 0,8'h01,8'h00,0,6,0);
    add_row(8'h41,0,0,-1,-1,1, 0,8'h01,8'h00,1,0,0);
    add_row(8'h00,0,0,-1, 8,0, 0,8'h00,8'h00,0,0,0);
    add_row(8'h00,0,0,-1,55,0, 0,8'h00,8'h00,0,0,0);
    // AEOI with automatic rotation
    add_row(8'h00,0,1,-1,32,0, 0,8'h00,8'h00,0,0,0);
    add_row(8'h03,0,1,-1,-1,0, 1,8'h00,8'h03,0,0,0);
    add_row(8'h03,0,1,-1,-1,1, 0,8'h01,8'h02,0,0,0);
    add_row(8'h03,0,1,-1,-1,1, 1,8'h00,8'h02,1,0,0);
    add_row(8'h03,0,1,-1,-1,1, 0,8'h02,8'h00,0,0,0);
    add_row(8'h03,0,1,-1,-1,1, 0,8'h00,8'h00,1,1,0);
    add_row(8'h00,0,0,-1, 0,0, 0,8'h00,8'h00,0,1,0);
    add_row(8'h00,0,0,-1,55,0, 0,8'h00,8'h00,0,1,0);
    // level mode: request survives acknowledge, re-asserts after EOI
    add_row(8'h04,1,0,-1,-1,0, 1,8'h00,8'h04,0,1,0);
    add_row(8'h04,1,0,-1,-1,1, 0,8'h04,8'h04,0,1,0);
    add_row(8'h04,1,0,-1,-1,1, 0,8'h04,8'h04,1,2,0);
    add_row(8'h04,1,0,-1, 8,0, 1,8'h00,8'h04,0,2,0);
    add_row(8'h00,1,0,-1,-1,0, 0,8'h00,8'h00,0,2,0);

    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    compare("reset int_o", int_o, 0);
    compare("reset irr", irr, 0);
    compare("reset isr", isr, 0);
    compare("reset imr", imr, 0);
    compare("reset vec_valid", vec_valid, 0);
    compare("reset vec", vec, 0);
    compare("reset spurious", spurious, 0);

    foreach (rows[i]) begin
      applyStimulus(rows[i].ir, rows[i].ltim, rows[i].aeoi, rows[i].imr, rows[i].cmd, rows[i].inta);
      checkOutput($sformatf("row%0d model", i));
      compare($sformatf("row%0d int_o", i),     int_o,     rows[i].e_int);
      compare($sformatf("row%0d isr", i),       isr,       rows[i].e_isr);
      compare($sformatf("row%0d irr", i),       irr,       rows[i].e_irr);
      compare($sformatf("row%0d vec_valid", i), vec_valid, rows[i].e_vv);
      compare($sformatf("row%0d vec", i),       vec,       rows[i].e_vec);
      compare($sformatf("row%0d spurious", i),  spurious,  rows[i].e_spur);
    end

    // reset between the two INTA pulses
    applyStimulus(8'h04, 0, 0, -1, -1, 0);
    compare("pre-reset int_o", int_o, 1);
    applyStimulus(8'h04, 0, 0, -1, -1, 1);
    compare("pre-reset isr", isr, 8'h04);
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    compare("async reset isr", isr, 0);
    compare("async reset irr", irr, 0);
    compare("async reset int_o", int_o, 0);
    compare("async reset vec_valid", vec_valid, 0);
    @(posedge clk);
    #1;
    compare("held reset vec_valid", vec_valid, 0);
    rst = 1'b0;
    applyStimulus(8'h04, 0, 0, -1, -1, 0);
    checkOutput("post-reset");
    compare("post-reset vec_valid", vec_valid, 0);
    compare("post-reset int_o", int_o, 1);
    applyStimulus(8'h04, 0, 0, -1, -1, 1);
    checkOutput("post-reset ack1");
    compare("post-reset ack1 isr", isr, 8'h04);
    compare("post-reset ack1 vec_valid", vec_valid, 0);
    applyStimulus(8'h04, 0, 0, -1, -1, 1);
    checkOutput("post-reset ack2");
    compare("post-reset ack2 vec_valid", vec_valid, 1);
    compare("post-reset ack2 vec", vec, 2);
    applyStimulus(8'h00, 0, 0, -1, 8, 0);
    checkOutput("post-reset eoi");

    r_ir = 8'h00;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      r_ir ^= 8'($urandom & $urandom & $urandom);
      r_imr = ($urandom_range(0, 19) == 0) ? int'($urandom_range(0, 255) & $urandom_range(0, 255)) : -1;
      r_cmd = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 63)) : -1;
      if (m_ack)            r_inta = ($urandom_range(0, 1) == 0);
      else if (model_int()) r_inta = ($urandom_range(0, 2) != 0);
      else                  r_inta = ($urandom_range(0, 29) == 0);
      applyStimulus(r_ir, ((cyc / 500) % 2) == 1, ((cyc / 250) % 2) == 1, r_imr, r_cmd, r_inta);
      checkOutput($sformatf("rand%0d", cyc));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
